hazard_forward_unit: RTL and testbench
======================================

HAZARD_FORWARD_UNIT -- requirements
Module: hazard_forward_unit

Interface
REQ-001 SHALL have parameter: REG_ADDR_W, 5, register-specifier width.
REQ-002 SHALL have port: clk  in  1  single clock, all state on rising edge.
REQ-003 SHALL have port: rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports: id_valid  in  1  ID holds a real instruction; id_rs, id_rt  in  REG_ADDR_W  source specifiers; id_uses_rs, id_uses_rt  in  1  source actually read.
REQ-005 SHALL have ports: id_rd  in  REG_ADDR_W  destination; id_reg_write  in  1  writes rd; id_mem_read  in  1  is a load.
REQ-006 SHALL have port: flush  in  1  branch/jump taken, squash instruction in ID.
REQ-007 SHALL have ports: stall  out  1  hold PC and IF/ID; ex_bubble  out  1  EX holds a bubble.
REQ-008 SHALL have ports: fwd_a_sel, fwd_b_sel  out  2  select for EX operand A/B three-way 32-bit muxes.

Function
REQ-009 SHALL keep shadow entries EX, MEM, WB, each {valid, rd, reg_write, mem_read}.
REQ-010 SHALL, each cycle, advance EX->MEM and MEM->WB unconditionally.
REQ-011 SHALL load EX from ID when stall=0 and flush=0; otherwise load EX with a bubble (valid=0).
REQ-012 SHALL assert stall combinationally when id_valid, EX.valid, EX.mem_read, EX.reg_write, EX.rd!=0 and (id_uses_rs and id_rs==EX.rd or id_uses_rt and id_rt==EX.rd).
REQ-013 SHALL force stall=0 when flush=1 (flush has priority).
REQ-014 SHALL limit each load-use hazard to exactly one stall cycle (bubble removes match next cycle).
REQ-015 SHALL register fwd_*_sel at the ID->EX transition, valid throughout the EX cycle.
REQ-016 SHALL encode select: 0 register file, 1 MEM-stage result, 2 WB-stage result; 3 never driven.
REQ-017 SHALL choose per operand: 1 if current EX entry valid, reg_write, rd!=0, rd==source; else 2 if current MEM entry matches the same way; else 0.
REQ-018 SHALL give the younger producer priority when both match.
REQ-019 SHALL drive 0 for an operand whose id_uses_* is 0 and never forward register 0.
REQ-020 SHALL drive both selects 0 and ex_bubble=1 when EX loads a bubble.
REQ-021 SHALL not forward from beyond WB; the register file writes before read in the same cycle.

Reset
REQ-022 SHALL, on rst_n low, immediately clear all shadow valid bits, fwd_a_sel=0, fwd_b_sel=0, ex_bubble=1.
REQ-023 SHALL keep stall=0 while in reset and on the first cycle after release.
REQ-024 SHALL discard in-flight hazard state when reset asserts mid-stall; no stall resumes after release.

Configuration
REQ-025 SHALL, with HAZARD_STAT_EN defined, add output stall_count (16 bits), reset to 0, incremented each cycle stall=1, saturating at 16'hFFFF.
REQ-026 SHALL, without HAZARD_STAT_EN, omit stall_count port and counter logic; all other behaviour identical.

Structure
REQ-027 SHALL take FWD_RF=2'd0, FWD_MEM=2'd1, FWD_WB=2'd2, REG_ADDR_W default and the shadow-entry struct from shared package pcpu_hazard_pkg.
REQ-028 SHALL implement each shadow entry with one reusable sub-module hazard_stage_reg (async-reset, bubble-load input).

Verification
REQ-029 SHALL cover: add r3 then add r4,r3,r5 next cycle -> fwd_a_sel=1 in consumer's EX cycle, stall=0.
REQ-030 SHALL cover: add r3, nop, sub r6,r7,r3 -> fwd_b_sel=2, fwd_a_sel=0.
REQ-031 SHALL cover: lw r2 then add r8,r2,r2 -> stall=1 one cycle, ex_bubble=1 next cycle, then fwd_a_sel=fwd_b_sel=1... after bubble both =2.
REQ-032 SHALL cover: add r0 then consumer of r0 -> selects 0; add r9 twice then consumer of r9 -> select 1.
REQ-033 SHALL cover: load-use hazard with flush=1 same cycle -> stall=0, ex_bubble=1, selects 0.
REQ-034 SHALL cover: rst_n low during stall -> outputs at reset values within same cycle; with HAZARD_STAT_EN, 3 stalls -> stall_count=3.

Source files
------------

// File: rtl/pcpu_hazard_pkg.sv
// -----------------------------------------------------------------------------
// pcpu_hazard_pkg
// Shared definitions for the pipeline hazard / forwarding logic.
//   HZ_REG_ADDR_W  : default register-specifier width
//   FWD_RF/MEM/WB  : operand-mux select encodings (3 is never produced)
//   hazard_entry_t : shadow copy of one pipeline stage {valid, rd, reg_write, mem_read}
//   HZ_BUBBLE      : an empty (invalid) shadow entry
//   fwd_match()    : true when an entry produces the given source register
// -----------------------------------------------------------------------------
package pcpu_hazard_pkg;

  localparam int HZ_REG_ADDR_W = 5;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_MEM = 2'd1;
  localparam logic [1:0] FWD_WB  = 2'd2;

  typedef struct packed {
    logic                     valid;
    logic [HZ_REG_ADDR_W-1:0] rd;
    logic                     reg_write;
    logic                     mem_read;
  } hazard_entry_t;

  localparam hazard_entry_t HZ_BUBBLE = '0;

  // Register 0 is hard-wired, so a write to it never produces a forwardable value.
  function automatic logic fwd_match(hazard_entry_t e, logic [HZ_REG_ADDR_W-1:0] src);
    return e.valid && e.reg_write && (e.rd != '0) && (e.rd == src);
  endfunction

endpackage

// File: rtl/hazard_stage_reg.sv
// -----------------------------------------------------------------------------
// hazard_stage_reg
// One shadow pipeline entry. Captures i_entry every cycle unless i_bubble is
// high, in which case an empty entry is loaded instead.
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset, clears the entry
//   i_bubble  in   load an empty entry this cycle
//   i_entry   in   entry from the previous stage
//   o_entry   out  registered entry
// -----------------------------------------------------------------------------
module hazard_stage_reg
  import pcpu_hazard_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_bubble,
  input  hazard_entry_t i_entry,
  output hazard_entry_t o_entry
);

  hazard_entry_t r_entry;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_entry <= HZ_BUBBLE;
    end else if (i_bubble) begin
      r_entry <= HZ_BUBBLE;
    end else begin
      r_entry <= i_entry;
    end
  end

  assign o_entry = r_entry;

endmodule

// File: rtl/hazard_forward_unit.sv
// -----------------------------------------------------------------------------
// hazard_forward_unit
// Load-use stall detection and EX operand forwarding selection for a classic
// 5-stage pipeline. Keeps shadow EX/MEM/WB entries describing what each stage
// will write, stalls ID for one cycle on a load-use hazard, and registers the
// EX operand-mux selects as the instruction moves from ID to EX.
//
// Optional feature: define HAZARD_STAT_EN to add the 16-bit saturating
// stall_count output.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   id_valid                      ID holds a real instruction
//   id_rs, id_rt                  ID source specifiers
//   id_uses_rs, id_uses_rt        source actually read
//   id_rd, id_reg_write           ID destination and its write enable
//   id_mem_read                   ID instruction is a load
//   flush                         squash the instruction in ID
//   stall                         hold PC and IF/ID (combinational)
//   ex_bubble                     EX currently holds a bubble
//   fwd_a_sel, fwd_b_sel          EX operand select: 0 RF, 1 MEM, 2 WB
//   stall_count                   (HAZARD_STAT_EN only) stall cycles seen
//
// The shadow-entry struct is sized by the package width; REG_ADDR_W is meant
// to be left at that value.
// -----------------------------------------------------------------------------
module hazard_forward_unit
  import pcpu_hazard_pkg::*;
#(
  parameter int REG_ADDR_W = HZ_REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  flush,
  output logic                  stall,
  output logic                  ex_bubble,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel
`ifdef HAZARD_STAT_EN
  ,
  output logic [15:0]           stall_count
`endif
);

  localparam int N_STAGES = 3;  // EX, MEM, WB

  hazard_entry_t w_stage_d      [N_STAGES];
  hazard_entry_t w_stage_q      [N_STAGES];
  logic          w_stage_bubble [N_STAGES];

  hazard_entry_t w_id_entry;
  hazard_entry_t w_ex;
  hazard_entry_t w_mem;
  logic          w_rs_hit;
  logic          w_rt_hit;
  logic          w_stall;
  logic          w_ex_load;
  logic [1:0]    w_fwd_a_next;
  logic [1:0]    w_fwd_b_next;

  logic [1:0]    r_fwd_a_sel;
  logic [1:0]    r_fwd_b_sel;
  logic          r_ex_bubble;

  assign w_ex  = w_stage_q[0];
  assign w_mem = w_stage_q[1];

  // ---------------------------------------------------------------------------
  // Load-use detection: the load in EX has no data until the end of MEM, so a
  // dependent instruction in ID must wait one cycle. A flush squashes ID, so
  // it overrides the stall.
  // ---------------------------------------------------------------------------
  assign w_rs_hit = id_uses_rs && (id_rs == w_ex.rd);
  assign w_rt_hit = id_uses_rt && (id_rt == w_ex.rd);

  assign w_stall = !flush && id_valid && w_ex.valid && w_ex.mem_read &&
                   w_ex.reg_write && (w_ex.rd != '0) && (w_rs_hit || w_rt_hit);

  assign stall     = w_stall;
  assign w_ex_load = id_valid && !w_stall && !flush;

  assign w_id_entry = '{valid:     id_valid,
                        rd:        id_rd,
                        reg_write: id_reg_write,
                        mem_read:  id_mem_read};

  // ---------------------------------------------------------------------------
  // Shadow pipeline EX -> MEM -> WB. Only EX can take a bubble; the later
  // stages always advance. WB is tracked so the pipeline picture is complete,
  // but nothing forwards from it: the register file writes before it is read.
  // ---------------------------------------------------------------------------
  assign w_stage_d[0]      = w_id_entry;
  assign w_stage_bubble[0] = !w_ex_load;

  genvar gi;
  generate
    for (gi = 1; gi < N_STAGES; gi++) begin : g_chain
      assign w_stage_d[gi]      = w_stage_q[gi-1];
      assign w_stage_bubble[gi] = 1'b0;
    end

    for (gi = 0; gi < N_STAGES; gi++) begin : g_stage
      hazard_stage_reg u_stage (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_bubble (w_stage_bubble[gi]),
        .i_entry  (w_stage_d[gi]),
        .o_entry  (w_stage_q[gi])
      );
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Forward select, evaluated while the consumer is still in ID. At the edge
  // the current EX producer moves to MEM and the current MEM producer moves to
  // WB, hence EX match -> MEM select and MEM match -> WB select. Checking EX
  // first gives the younger producer priority.
  // ---------------------------------------------------------------------------
  function automatic logic [1:0] pick_src(logic uses, logic [REG_ADDR_W-1:0] src,
                                          hazard_entry_t ex_e, hazard_entry_t mem_e);
    if (!uses) begin
      return FWD_RF;
    end else if (fwd_match(ex_e, src)) begin
      return FWD_MEM;
    end else if (fwd_match(mem_e, src)) begin
      return FWD_WB;
    end
    return FWD_RF;
  endfunction

  assign w_fwd_a_next = pick_src(id_uses_rs, id_rs, w_ex, w_mem);
  assign w_fwd_b_next = pick_src(id_uses_rt, id_rt, w_ex, w_mem);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fwd_a_sel <= FWD_RF;
      r_fwd_b_sel <= FWD_RF;
      r_ex_bubble <= 1'b1;
    end else if (w_ex_load) begin
      r_fwd_a_sel <= w_fwd_a_next;
      r_fwd_b_sel <= w_fwd_b_next;
      r_ex_bubble <= 1'b0;
    end else begin
      r_fwd_a_sel <= FWD_RF;
      r_fwd_b_sel <= FWD_RF;
      r_ex_bubble <= 1'b1;
    end
  end

  assign fwd_a_sel = r_fwd_a_sel;
  assign fwd_b_sel = r_fwd_b_sel;
  assign ex_bubble = r_ex_bubble;

`ifdef HAZARD_STAT_EN
  // Stall-cycle counter, sticks at all-ones instead of wrapping.
  logic [15:0] r_stall_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_count <= '0;
    end else if (w_stall && (r_stall_count != 16'hFFFF)) begin
      r_stall_count <= r_stall_count + 16'd1;
    end
  end

  assign stall_count = r_stall_count;
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_forward_unit
// Self-checking bench: a table of directed pipeline sequences, randomized
// traffic against a history-based reference model, and a reset-during-stall
// sequence. Build with HAZARD_STAT_EN defined to also check stall_count.
// -----------------------------------------------------------------------------
module tb_hazard_forward_unit;

  logic       clk;
  logic       rst_n;
  logic       id_valid;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_uses_rs;
  logic       id_uses_rt;
  logic [4:0] id_rd;
  logic       id_reg_write;
  logic       id_mem_read;
  logic       flush;
  logic       stall;
  logic       ex_bubble;
  logic [1:0] fwd_a_sel;
  logic [1:0] fwd_b_sel;
`ifdef HAZARD_STAT_EN
  logic [15:0] stall_count;
`endif

  hazard_forward_unit #(.REG_ADDR_W(5)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_valid     (id_valid),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rs   (id_uses_rs),
    .id_uses_rt   (id_uses_rt),
    .id_rd        (id_rd),
    .id_reg_write (id_reg_write),
    .id_mem_read  (id_mem_read),
    .flush        (flush),
    .stall        (stall),
    .ex_bubble    (ex_bubble),
    .fwd_a_sel    (fwd_a_sel),
    .fwd_b_sel    (fwd_b_sel)
`ifdef HAZARD_STAT_EN
    ,
    .stall_count  (stall_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Vectors and reference model
  // ---------------------------------------------------------------------------
  typedef struct {
    logic       v;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic [4:0] rd;
    logic       rw;
    logic       mr;
    logic       fl;
    logic       e_stall;
    logic [1:0] e_a;
    logic [1:0] e_b;
    logic       e_bub;
  } vec_t;

  // What an instruction that entered EX some cycles ago will write.
  typedef struct {
    logic       v;
    logic [4:0] rd;
    logic       rw;
    logic       mr;
  } prod_t;

  // hist[d] = instruction that entered EX d+1 edges before the coming one.
  prod_t hist [2];
  int    exp_cnt;
  int    checks;
  int    failures;

  function automatic vec_t mk(logic v, logic [4:0] rs, logic [4:0] rt, logic urs, logic urt,
                              logic [4:0] rd, logic rw, logic mr, logic fl,
                              logic es, logic [1:0] ea, logic [1:0] eb, logic ebub);
    vec_t x;
    x.v = v; x.rs = rs; x.rt = rt; x.urs = urs; x.urt = urt;
    x.rd = rd; x.rw = rw; x.mr = mr; x.fl = fl;
    x.e_stall = es; x.e_a = ea; x.e_b = eb; x.e_bub = ebub;
    return x;
  endfunction

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      hist[d].v  = 1'b0;
      hist[d].rd = '0;
      hist[d].rw = 1'b0;
      hist[d].mr = 1'b0;
    end
    exp_cnt = 0;
  endfunction

  // A load one cycle ahead whose result the ID instruction reads cannot be
  // forwarded in time; a flush discards the ID instruction anyway.
  function automatic logic m_stall(vec_t x);
    if (x.fl || !x.v) return 1'b0;
    if (!(hist[0].v && hist[0].mr && hist[0].rw && hist[0].rd != 0)) return 1'b0;
    return (x.urs && x.rs == hist[0].rd) || (x.urt && x.rt == hist[0].rd);
  endfunction

  // Nearest earlier writer of src: one ahead -> its result is in MEM (1),
  // two ahead -> in WB (2). Older values come from the register file.
  function automatic logic [1:0] m_sel(logic u, logic [4:0] s);
    if (!u || s == 0) return 2'd0;
    for (int d = 0; d < 2; d++) begin
      if (hist[d].v && hist[d].rw && hist[d].rd == s) return 2'(d + 1);
    end
    return 2'd0;
  endfunction

  function automatic void chk(string nm, logic [15:0] act, logic [15:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endfunction

  // One cycle: drive ID at posedge+1, check stall mid-cycle, then check the
  // registered outputs after the edge. Returns at posedge+1.
  task automatic step(input vec_t x, input bit use_model, input string tag);
    logic       es, ld, ebub;
    logic [1:0] ea, eb;
    prod_t      p;
    id_valid     = x.v;
    id_rs        = x.rs;
    id_rt        = x.rt;
    id_uses_rs   = x.urs;
    id_uses_rt   = x.urt;
    id_rd        = x.rd;
    id_reg_write = x.rw;
    id_mem_read  = x.mr;
    flush        = x.fl;
    es   = m_stall(x);
    ld   = x.v && !x.fl && !es;
    ea   = ld ? m_sel(x.urs, x.rs) : 2'd0;
    eb   = ld ? m_sel(x.urt, x.rt) : 2'd0;
    ebub = !ld;
    p.v  = ld; p.rd = x.rd; p.rw = x.rw; p.mr = x.mr;
    if (!use_model) begin
      es = x.e_stall; ea = x.e_a; eb = x.e_b; ebub = x.e_bub;
    end
    #3;
    chk({tag, " stall"}, 16'(stall), 16'(es));
    @(posedge clk);
    hist[1] = hist[0];
    hist[0] = p;
    if (m_stall(x) && exp_cnt < 65535) exp_cnt++;
    #1;
    chk({tag, " fwd_a_sel"}, 16'(fwd_a_sel), 16'(ea));
    chk({tag, " fwd_b_sel"}, 16'(fwd_b_sel), 16'(eb));
    chk({tag, " ex_bubble"}, 16'(ex_bubble), 16'(ebub));
    $display("%-8s v=%0d rs=%0d rt=%0d rd=%0d rw=%0d mr=%0d fl=%0d | stall=%0d a=%0d b=%0d bub=%0d",
             tag, x.v, x.rs, x.rt, x.rd, x.rw, x.mr, x.fl, stall, fwd_a_sel, fwd_b_sel, ex_bubble);
  endtask

  vec_t tbl [16];
  vec_t lw2, use2;

  initial begin
    checks   = 0;
    failures = 0;
    model_reset();
    rst_n = 1'b0;
    id_valid = 0; id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
    id_rd = 0; id_reg_write = 0; id_mem_read = 0; flush = 0;

    //            v rs rt urs urt rd rw mr fl  stall a b bub
    tbl[0]  = mk(1, 1, 2, 1, 1,  3, 1, 0, 0,  0, 0, 0, 0);  // add r3,r1,r2
    tbl[1]  = mk(1, 3, 5, 1, 1,  4, 1, 0, 0,  0, 1, 0, 0);  // add r4,r3,r5 -> A from MEM
    tbl[2]  = mk(1, 1, 1, 1, 1,  3, 1, 0, 0,  0, 0, 0, 0);  // add r3,r1,r1
    tbl[3]  = mk(0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 1);  // nop
    tbl[4]  = mk(1, 7, 3, 1, 1,  6, 1, 0, 0,  0, 0, 2, 0);  // sub r6,r7,r3 -> B from WB
    tbl[5]  = mk(1, 1, 0, 1, 0,  2, 1, 1, 0,  0, 0, 0, 0);  // lw r2,0(r1)
    tbl[6]  = mk(1, 2, 2, 1, 1,  8, 1, 0, 0,  1, 0, 0, 1);  // add r8,r2,r2 stalls
    tbl[7]  = mk(1, 2, 2, 1, 1,  8, 1, 0, 0,  0, 2, 2, 0);  // retried: both from WB
    tbl[8]  = mk(1, 1, 1, 1, 1,  0, 1, 0, 0,  0, 0, 0, 0);  // add r0,r1,r1
    tbl[9]  = mk(1, 0, 0, 1, 1, 10, 1, 0, 0,  0, 0, 0, 0);  // add r10,r0,r0: no r0 forward
    tbl[10] = mk(1, 1, 1, 1, 1,  9, 1, 0, 0,  0, 0, 0, 0);  // add r9
    tbl[11] = mk(1, 1, 1, 1, 1,  9, 1, 0, 0,  0, 0, 0, 0);  // add r9 again
    tbl[12] = mk(1, 9, 9, 1, 1, 11, 1, 0, 0,  0, 1, 1, 0);  // younger r9 wins
    tbl[13] = mk(1, 1, 0, 1, 0,  5, 1, 1, 0,  0, 0, 0, 0);  // lw r5
    tbl[14] = mk(1, 5, 0, 1, 1,  6, 1, 0, 1,  0, 0, 0, 1);  // load-use + flush
    tbl[15] = mk(1, 5, 5, 0, 1,  7, 1, 0, 0,  0, 0, 2, 0);  // rs unused, rt from WB

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset stall", 16'(stall), 16'd0);
    chk("reset ex_bubble", 16'(ex_bubble), 16'd1);
    chk("reset fwd_a_sel", 16'(fwd_a_sel), 16'd0);
    chk("reset fwd_b_sel", 16'(fwd_b_sel), 16'd0);
`ifdef HAZARD_STAT_EN
    chk("reset stall_count", stall_count, 16'd0);
`endif
    rst_n = 1'b1;

    // Directed table
    for (int i = 0; i < 16; i++) begin
      step(tbl[i], 1'b0, $sformatf("tbl%0d", i));
    end

    // Randomized traffic on a small register range so hazards are frequent
    for (int i = 0; i < 300; i++) begin
      vec_t r;
      r = mk(($urandom % 8) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             ($urandom % 4) != 0, ($urandom % 4) != 0, 5'($urandom_range(0, 3)),
             ($urandom % 5) != 0, ($urandom % 3) == 0, ($urandom % 10) == 0,
             0, 0, 0, 0);
      step(r, 1'b1, $sformatf("rnd%0d", i));
    end
`ifdef HAZARD_STAT_EN
    chk("rnd stall_count", stall_count, 16'(exp_cnt));
`endif

    // Reset asserted in the middle of a load-use stall
    lw2  = mk(1, 1, 0, 1, 0, 2, 1, 1, 0, 0, 0, 0, 0);
    use2 = mk(1, 2, 2, 1, 1, 8, 1, 0, 0, 0, 0, 0, 0);
    step(lw2, 1'b1, "rs_lw");
    id_valid = 1; id_rs = 2; id_rt = 2; id_uses_rs = 1; id_uses_rt = 1;
    id_rd = 8; id_reg_write = 1; id_mem_read = 0; flush = 0;
    #2;
    chk("pre-reset stall", 16'(stall), 16'd1);
    rst_n = 1'b0;
    #1;
    chk("async reset stall", 16'(stall), 16'd0);
    chk("async reset ex_bubble", 16'(ex_bubble), 16'd1);
    chk("async reset fwd_a_sel", 16'(fwd_a_sel), 16'd0);
    chk("async reset fwd_b_sel", 16'(fwd_b_sel), 16'd0);
    $display("rst_mid  stall=%0d a=%0d b=%0d bub=%0d", stall, fwd_a_sel, fwd_b_sel, ex_bubble);
    @(posedge clk);
    #1;
    chk("in reset stall", 16'(stall), 16'd0);
    rst_n = 1'b1;
    model_reset();
    step(use2, 1'b1, "rs_rel");

    // Three load-use hazards
    for (int k = 0; k < 3; k++) begin
      step(lw2,  1'b1, $sformatf("cnt_lw%0d", k));
      step(use2, 1'b1, $sformatf("cnt_st%0d", k));
      step(use2, 1'b1, $sformatf("cnt_go%0d", k));
    end
`ifdef HAZARD_STAT_EN
    chk("stall_count after 3 stalls", stall_count, 16'(exp_cnt));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
